keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment driver: scans a 4x4 matrix keypad (Pmod KYPD) on a JA-class header by driving one column low at a time and reading the rows.
- Debounces, decodes to a 4-bit hex key code and shifts accepted keys into a 4-digit register, D3..D0, that feeds the display block directly.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_debounce_fsm.sv | 110 +++++++++++
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the keypad key map for the matrix keypad scanner.
package keypad_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kp_state_e;

  // Outcome of one full four-column scan.
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } kp_result_e;

  // Column drive after reset: column 0 low.
  localparam logic [3:0] COL_INIT = 4'b1110;

  // Printed legend of the Pmod KYPD, row r / column c.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Press/release debouncer: consumes one result per full scan and accepts a key
// after DEBOUNCE_SCANS identical single-key scans; no rollover while held.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter logic [2:0] DEBOUNCE_SCANS = 3'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       res_stb,
  input  logic [1:0] res_type,
  input  logic [3:0] res_code,
  output logic       accept_now,
  output logic [3:0] cand_code,
  output logic       accept,
  output logic [3:0] acc_code,
  output logic       held
);

  kp_state_e  state, state_nxt;
  kp_result_e res;
  logic [2:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0] cand, cand_nxt;

  assign res       = kp_result_e'(res_type);
  assign cnt_inc   = cnt + 3'd1;
  assign cand_code = cand;
  assign held      = (state == HELD) || (state == RELEASE_WAIT);

  // State, candidate and debounce count registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 3'd0;
      cand  <= 4'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // Next state; only a scan-result strobe can move the machine.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_nxt   = cand;
    accept_now = 1'b0;
    if (res_stb) begin
      case (state)
        IDLE: begin
          if (res == RES_SINGLE) begin
            cand_nxt  = res_code;
            cnt_nxt   = 3'd1;
            state_nxt = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (res == RES_SINGLE && res_code == cand) begin
            if (cnt_inc == DEBOUNCE_SCANS) begin
              accept_now = 1'b1;
              cnt_nxt    = 3'd0;
              state_nxt  = HELD;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt   = 3'd0;
            state_nxt = IDLE;
          end
        end
        HELD: begin
          if (res == RES_NONE) begin
            cnt_nxt   = 3'd1;
            state_nxt = RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (res == RES_NONE) begin
            if (cnt_inc == DEBOUNCE_SCANS) begin
              cnt_nxt   = 3'd0;
              state_nxt = IDLE;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt   = 3'd0;
            state_nxt = HELD;
          end
        end
        default: begin
          cnt_nxt   = 3'd0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Accept pulse lasts one cycle; the accepted code holds until the next accept.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      accept   <= 1'b0;
      acc_code <= 4'h0;
    end else begin
      accept <= accept_now;
      if (accept_now) acc_code <= cand;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, per-scan key
// accumulation, debounce and a 4-digit shift register for the display.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [31:0] SCAN_DIV       = 32'd100_000,
  parameter logic [2:0]  DEBOUNCE_SCANS = 3'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_VALID,
  output logic        KEY_HELD,
  output logic [15:0] DIGITS
);

  logic [3:0]  row_meta, row_sync;
  logic [31:0] dwell_cnt;
  logic        carry;
  logic [3:0]  col_q;
  logic [1:0]  col_idx;

  logic [3:0]  lows;
  logic        col_hit, col_two;
  logic [1:0]  row_idx;

  logic        acc_seen, acc_multi;
  logic [3:0]  acc_code;
  logic        seen_nxt, multi_nxt;
  logic [3:0]  code_nxt;

  logic        last_col, res_stb;
  logic [1:0]  res_type;
  logic        accept_now;
  logic [3:0]  cand_code;
  logic [15:0] digits_q;

  // ROW is asynchronous to CLK: two-flop synchronizer, idle-high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= ROW;
      row_sync <= row_meta;
    end
  end

  assign carry = (dwell_cnt == SCAN_DIV);

  // Column dwell counter, 0..SCAN_DIV.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      dwell_cnt <= 32'd0;
    else if (carry) dwell_cnt <= 32'd0;
    else            dwell_cnt <= dwell_cnt + 32'd1;
  end

  // Walk the single low bit left at the end of each dwell.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      col_q <= COL_INIT;
    else if (carry) col_q <= {col_q[2:0], col_q[3]};
  end

  assign COL      = col_q;
  assign last_col = (col_q == 4'b0111);

  // Index of the column currently driven low.
  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Decode the sampled rows for this column: any hit, two or more hits, which row.
  always_comb begin
    lows    = ~row_sync;
    col_hit = |lows;
    col_two = (lows & (lows - 4'd1)) != 4'd0;
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (lows[r]) row_idx = 2'(r);
    end
  end

  // Fold this column into the running scan; a hit after any earlier hit is multi.
  always_comb begin
    seen_nxt  = acc_seen | col_hit;
    multi_nxt = acc_multi | col_two | (acc_seen & col_hit);
    code_nxt  = (col_hit && !acc_seen) ? key_map(row_idx, col_idx) : acc_code;
  end

  // Scan accumulator; cleared once the last column has been folded in.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc_seen  <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'h0;
    end else if (carry) begin
      if (last_col) begin
        acc_seen  <= 1'b0;
        acc_multi <= 1'b0;
        acc_code  <= 4'h0;
      end else begin
        acc_seen  <= seen_nxt;
        acc_multi <= multi_nxt;
        acc_code  <= code_nxt;
      end
    end
  end

  // The result includes the last column's sample, so it is formed combinationally.
  assign res_stb  = carry & last_col;
  assign res_type = multi_nxt ? RES_MULTI : (seen_nxt ? RES_SINGLE : RES_NONE);

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .CLK       (CLK),
    .RESET     (RESET),
    .res_stb   (res_stb),
    .res_type  (res_type),
    .res_code  (code_nxt),
    .accept_now(accept_now),
    .cand_code (cand_code),
    .accept    (KEY_VALID),
    .acc_code  (KEY_CODE),
    .held      (KEY_HELD)
  );

  // Newest key enters D0 on the same edge KEY_CODE updates; D3 falls off.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           digits_q <= 16'h0000;
    else if (accept_now) digits_q <= {digits_q[11:0], cand_code};
  end

  assign DIGITS = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scan-level bench: a keypad model drives ROW from COL, key sets change once
// per full scan, and a scan-by-scan reference predicts pulses, hold and digits.
module tb_keypad_scanner;

  localparam int DS = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic [3:0]  KEY_CODE;
  logic        KEY_VALID;
  logic        KEY_HELD;
  logic [15:0] DIGITS;

  logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c pressed

  int nvec = 0;
  int nerr = 0;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'h0, 4'hF, 4'hE, 4'hD};

  // reference state
  bit         m_held;
  int         m_streak, m_rel;
  logic [3:0] m_cand, m_code;
  int         m_digits;
  int         exp_pulse;

  keypad_scanner #(
    .SCAN_DIV      (32'd3),
    .DEBOUNCE_SCANS(3'd2)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ROW      (ROW),
    .COL      (COL),
    .KEY_CODE (KEY_CODE),
    .KEY_VALID(KEY_VALID),
    .KEY_HELD (KEY_HELD),
    .DIGITS   (DIGITS)
  );

  always #5 CLK = ~CLK;

  // Physical keypad: a row reads low iff a pressed key sits on a driven-low column.
  always_comb begin
    ROW = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_streak = 0; m_rel = 0;
    m_cand = 4'h0; m_code = 4'h0; m_digits = 0; exp_pulse = 0;
  endtask

  // One scan's worth of debouncing, from the key set held during that scan.
  task automatic model_step(input logic [15:0] mask);
    int n;
    logic [3:0] k;
    n = $countones(mask);
    k = 4'h0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = kmap[i];
    exp_pulse = 0;
    if (!m_held) begin
      if (m_streak > 0) begin
        if (n == 1 && k == m_cand) begin
          m_streak++;
          if (m_streak == DS) begin
            exp_pulse = 1;
            m_code    = m_cand;
            m_digits  = (m_digits * 16 + int'(m_cand)) % 65536;
            m_held    = 1;
            m_streak  = 0;
            m_rel     = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else if (n == 1) begin
        m_streak = 1;
        m_cand   = k;
      end
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == DS) begin
          m_held = 0;
          m_rel  = 0;
        end
      end else begin
        m_rel = 0;
      end
    end
  endtask

  // Called at the first negedge of a scan; returns at the first negedge of the next.
  task automatic run_scan(input logic [15:0] mask);
    int pulses;
    logic [3:0] ec;
    pulses = 0;
    keys = mask;
    chk("held", KEY_HELD, m_held);
    chk("code", KEY_CODE, m_code);
    chk("digits", DIGITS, m_digits);
    for (int i = 0; i < 16; i++) begin
      ec = 4'b1111;
      ec[i/4] = 1'b0;
      chk("col", COL, ec);
      if (KEY_VALID) pulses++;
      @(negedge CLK);
    end
    chk("pulses", pulses, exp_pulse);
    model_step(mask);
  endtask

  task automatic scans(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) run_scan(mask);
  endtask

  // Reset part-way into a scan, while keys stay as they are.
  task automatic do_reset();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (KEY_VALID) pulses++;
      @(negedge CLK);
    end
    chk("pulse_pre_rst", pulses, exp_pulse);
    #2 RESET = 1'b1;
    #1;
    chk("rst_col", COL, 4'b1110);
    chk("rst_digits", DIGITS, 16'h0000);
    chk("rst_held", KEY_HELD, 1'b0);
    chk("rst_valid", KEY_VALID, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] mask;
    int hold;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("init_col", COL, 4'b1110);
    chk("init_valid", KEY_VALID, 1'b0);
    chk("init_held", KEY_HELD, 1'b0);
    chk("init_code", KEY_CODE, 4'h0);
    chk("init_digits", DIGITS, 16'h0000);
    RESET = 1'b0;

    // idle
    scans(16'h0, 4);
    // "5" for five scans, then release
    scans(16'h0020, 5);
    scans(16'h0, 3);
    chk("digits_5", DIGITS, 16'h0005);
    // 1, 2, 3, A, 7
    scans(16'h0001, 3); scans(16'h0, 3);
    scans(16'h0002, 3); scans(16'h0, 3);
    scans(16'h0004, 3); scans(16'h0, 3);
    scans(16'h0008, 3); scans(16'h0, 3);
    chk("digits_A", DIGITS, 16'h123A);
    scans(16'h0100, 3); scans(16'h0, 3);
    chk("digits_7", DIGITS, 16'h23A7);
    // bounce on "9"
    scans(16'h0400, 1); scans(16'h0, 2);
    for (int i = 0; i < 3; i++) begin
      scans(16'h0400, 1); scans(16'h0, 1);
    end
    scans(16'h0, 2);
    chk("digits_bounce", DIGITS, 16'h23A7);
    // multi-key from idle, then rollover attempt while held
    scans(16'h0401, 3); scans(16'h0, 2);
    scans(16'h0020, 3);
    scans(16'h0060, 3);
    scans(16'h0020, 1);
    scans(16'h0, 3);
    chk("digits_multi", DIGITS, 16'h3A75);
    // reset while "7" is in press-wait; still held afterwards
    scans(16'h0100, 1);
    do_reset();
    scans(16'h0100, 3);
    scans(16'h0, 3);
    chk("digits_after_rst", DIGITS, 16'h0007);

    // random key traffic, each key set held for a few scans
    for (int s = 0; s < 60; ) begin
      int kind;
      kind = $urandom_range(0, 9);
      mask = 16'h0;
      if (kind >= 4) mask[$urandom_range(0, 15)] = 1'b1;
      if (kind == 9) mask[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 4);
      scans(mask, hold);
      s += hold;
    end
    scans(16'h0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
